// File: rtl/gray_to_rgb_colorizer_pkg.sv
//------------------------------------------------------------------------------
// Module   : gray_to_rgb_colorizer_pkg
// Brief    : Shared widths, channel slices, FSM states and helpers for the colorizer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package gray_to_rgb_colorizer_pkg;

    localparam int c_PIX_W     = 24;
    localparam int c_GRAY_W    = 8;
    localparam int c_PAL_DEPTH = 256;
    localparam int c_PAL_AW    = 8;

    localparam int c_R_LSB = 16;
    localparam int c_G_LSB = 8;
    localparam int c_B_LSB = 0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [c_PIX_W-1:0] gray_replicate(input logic [c_GRAY_W-1:0] g);
        logic [c_PIX_W-1:0] p;
        p = '0;
        p[c_R_LSB +: c_GRAY_W] = g;
        p[c_G_LSB +: c_GRAY_W] = g;
        p[c_B_LSB +: c_GRAY_W] = g;
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_rgb_colorizer_palette_ram.sv
//------------------------------------------------------------------------------
// Module   : palette_ram_256x24
// Brief    : 256 x 24 palette, one write port, one read-first registered read port.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module palette_ram_256x24
    import gray_to_rgb_colorizer_pkg::*;
(
    input  logic                clk,
    input  logic                we_i,
    input  logic [c_PAL_AW-1:0] waddr_i,
    input  logic [c_PIX_W-1:0]  wdata_i,
    input  logic                re_i,
    input  logic [c_PAL_AW-1:0] raddr_i,
    output logic [c_PIX_W-1:0]  rdata_o
);

    logic [c_PIX_W-1:0] mem_q [c_PAL_DEPTH];
    logic [c_PIX_W-1:0] rdata_q;

    // Read and write share one block, so a same-address read sees the old entry.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/gray_to_rgb_colorizer.sv
//------------------------------------------------------------------------------
// Module   : gray_to_rgb_colorizer
// Brief    : Two-stage gray-to-RGB palette lookup with valid/ready streaming.
//            GRAY_TO_RGB_PALETTE_INIT_EN loads an identity palette after reset.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_to_rgb_colorizer
    import gray_to_rgb_colorizer_pkg::*;
#(
    parameter int GRAY_LSB = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [c_PIX_W-1:0]  s_pixel,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [c_PIX_W-1:0]  m_pixel,
    input  logic                pal_we,
    input  logic [c_PAL_AW-1:0] pal_addr,
    input  logic [c_PIX_W-1:0]  pal_data,
    output logic                busy,
    output logic                status
);

    logic                w_busy;
    logic                w_pal_we;
    logic [c_PAL_AW-1:0] w_pal_waddr;
    logic [c_PIX_W-1:0]  w_pal_wdata;
    logic [c_PIX_W-1:0]  w_pal_rdata;
    logic                w_s2_load;
    logic                w_s_ready;
    logic                w_s_fire;

`ifdef GRAY_TO_RGB_PALETTE_INIT_EN
    state_e              state_q, state_d;
    logic [c_PAL_AW-1:0] init_cnt_q, init_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 8'd1;
                if (init_cnt_q == 8'hFF) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Software writes are dropped while the identity fill owns the write port.
    always_comb begin
        w_busy      = 1'b0;
        w_pal_we    = pal_we;
        w_pal_waddr = pal_addr;
        w_pal_wdata = pal_data;
        if (state_q == ST_INIT) begin
            w_busy      = 1'b1;
            w_pal_we    = 1'b1;
            w_pal_waddr = init_cnt_q;
            w_pal_wdata = gray_replicate(init_cnt_q);
        end
    end
`else
    assign w_busy      = 1'b0;
    assign w_pal_we    = pal_we;
    assign w_pal_waddr = pal_addr;
    assign w_pal_wdata = pal_data;
`endif

    logic                s1_valid_q, s1_valid_d;
    logic [c_PIX_W-1:0]  s1_pixel_q, s1_pixel_d;
    logic                s1_en_q,    s1_en_d;
    logic                m_valid_q,  m_valid_d;
    logic [c_PIX_W-1:0]  m_pixel_q,  m_pixel_d;

    // Stage 1 only ever drains into stage 2, so both advance on the same condition.
    assign w_s2_load = !m_valid_q || m_ready;
    assign w_s_ready = !w_busy && w_s2_load;
    assign w_s_fire  = s_valid && w_s_ready;

    palette_ram_256x24 u_palette (
        .clk     (clk),
        .we_i    (w_pal_we),
        .waddr_i (w_pal_waddr),
        .wdata_i (w_pal_wdata),
        .re_i    (w_s_fire),
        .raddr_i (s_pixel[GRAY_LSB +: c_GRAY_W]),
        .rdata_o (w_pal_rdata)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pixel_d = s1_pixel_q;
        s1_en_d    = s1_en_q;
        m_valid_d  = m_valid_q;
        m_pixel_d  = m_pixel_q;
        if (w_s2_load) begin
            s1_valid_d = w_s_fire;
            m_valid_d  = s1_valid_q;
            if (s1_valid_q) begin
                m_pixel_d = s1_en_q ? w_pal_rdata : s1_pixel_q;
            end
        end
        if (w_s_fire) begin
            s1_pixel_d = s_pixel;
            s1_en_d    = en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pixel_q <= '0;
            s1_en_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            m_pixel_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pixel_q <= s1_pixel_d;
            s1_en_q    <= s1_en_d;
            m_valid_q  <= m_valid_d;
            m_pixel_q  <= m_pixel_d;
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = m_valid_q;
    assign m_pixel = m_pixel_q;
    assign busy    = w_busy;
    assign status  = en;

endmodule

`default_nettype wire

// File: tb/tb_gray_to_rgb_colorizer.sv
//------------------------------------------------------------------------------
// Module   : tb_gray_to_rgb_colorizer
// Brief    : Directed self-checking bench for gray_to_rgb_colorizer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_to_rgb_colorizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_pixel;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_pixel;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [23:0] pal_data;
    logic        busy;
    logic        status;

    int errors = 0;
    int checks = 0;
    logic [23:0] pal_m [256];

    always #5 clk = ~clk;

    gray_to_rgb_colorizer #(.GRAY_LSB(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_pixel  (s_pixel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_pixel  (m_pixel),
        .pal_we   (pal_we),
        .pal_addr (pal_addr),
        .pal_data (pal_data),
        .busy     (busy),
        .status   (status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_identity();
        for (int i = 0; i < 256; i++) pal_m[i] = {3{8'(i)}};
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        tick();
        pal_we = 1'b0;
        pal_m[a] = d;
    endtask

    task automatic program_identity();
        for (int i = 0; i < 256; i++) pal_write(8'(i), {3{8'(i)}});
    endtask

    task automatic test_reset();
        int n;
        int bad;
        rst_n = 1'b0; en = 1'b1; s_valid = 1'b1; s_pixel = 24'hABCDEF; m_ready = 1'b1;
        pal_we = 1'b0; pal_addr = 8'h00; pal_data = 24'h0;
        tick(); tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++; if (m_pixel !== 24'h0) begin errors++; $display("FAIL reset_m_pixel got=%h exp=000000", m_pixel); end
        checks++; if (status !== 1'b1) begin errors++; $display("FAIL status_hi got=%0b exp=1", status); end
        en = 1'b0; #1;
        checks++; if (status !== 1'b0) begin errors++; $display("FAIL status_lo got=%0b exp=0", status); end
        s_valid = 1'b0;
        rst_n = 1'b1;
`ifdef GRAY_TO_RGB_PALETTE_INIT_EN
        // Software writes during INIT must be ignored.
        pal_we = 1'b1; pal_addr = 8'h55; pal_data = 24'hDEADBE;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 400) begin
            if (s_ready !== 1'b0) bad++;
            n++;
            tick();
        end
        pal_we = 1'b0;
        checks++; if (n !== 256) begin errors++; $display("FAIL init_busy_cycles got=%0d exp=256", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_s_ready_high got=%0d exp=0", bad); end
        model_identity();
`else
        n = 0; bad = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_tied got=%0b exp=0", busy); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL s_ready_run got=%0b exp=1", s_ready); end
`endif
    endtask

    task automatic test_latency();
        logic [23:0] vin [2];
        logic [23:0] vexp [2];
        vin[0] = 24'h404040; vexp[0] = 24'h404040;
        vin[1] = 24'h555555; vexp[1] = 24'h555555;
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1; s_pixel = vin[k]; en = 1'b1;
            tick();
            s_valid = 1'b0;
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_early%0d m_valid got=%0b exp=0", k, m_valid); end
            tick();
            checks++; if (m_valid !== 1'b1 || m_pixel !== vexp[k]) begin
                errors++; $display("FAIL lat%0d got v=%0b p=%h exp v=1 p=%h", k, m_valid, m_pixel, vexp[k]); end
            tick();
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_after%0d m_valid got=%0b exp=0", k, m_valid); end
        end
    endtask

    task automatic test_palette_write();
        pal_write(8'h80, 24'hFF0000);
        s_valid = 1'b1; s_pixel = 24'h808080; en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_pixel !== 24'hFF0000) begin
            errors++; $display("FAIL pal_en1 got v=%0b p=%h exp v=1 p=ff0000", m_valid, m_pixel); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_pixel !== 24'h808080) begin
            errors++; $display("FAIL pal_en0 got v=%0b p=%h exp v=1 p=808080", m_valid, m_pixel); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pal_drain got=%0b exp=0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] vin [6];
        logic        ven [6];
        logic [23:0] vexp [6];
        pal_write(8'h20, 24'h123456);
        pal_write(8'h21, 24'hABCDEF);
        vin[0] = 24'h202020; ven[0] = 1'b1; vexp[0] = 24'h123456;
        vin[1] = 24'h212121; ven[1] = 1'b1; vexp[1] = 24'hABCDEF;
        vin[2] = 24'h212121; ven[2] = 1'b0; vexp[2] = 24'h212121;
        vin[3] = 24'h202020; ven[3] = 1'b0; vexp[3] = 24'h202020;
        vin[4] = 24'h112033; ven[4] = 1'b1; vexp[4] = 24'h123456;
        vin[5] = 24'h112033; ven[5] = 1'b0; vexp[5] = 24'h112033;
        m_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                s_valid = 1'b1; s_pixel = vin[k]; en = ven[k];
                #1;
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%0b exp=1", k, s_ready); end
            end else begin
                s_valid = 1'b0;
            end
            tick();
            if (k >= 1) begin
                checks++; if (m_valid !== 1'b1 || m_pixel !== vexp[k-1]) begin
                    errors++; $display("FAIL b2b%0d got v=%0b p=%h exp v=1 p=%h", k-1, m_valid, m_pixel, vexp[k-1]); end
            end
        end
        tick();
    endtask

    task automatic test_read_first();
        pal_we = 1'b1; pal_addr = 8'h10; pal_data = 24'hC0FFEE;
        s_valid = 1'b1; s_pixel = 24'h101010; en = 1'b1; m_ready = 1'b1;
        tick();
        pal_we = 1'b0;
        pal_m[8'h10] = 24'hC0FFEE;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_pixel !== 24'h101010) begin
            errors++; $display("FAIL rf_old got v=%0b p=%h exp v=1 p=101010", m_valid, m_pixel); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_pixel !== 24'hC0FFEE) begin
            errors++; $display("FAIL rf_new got v=%0b p=%h exp v=1 p=c0ffee", m_valid, m_pixel); end
        tick();
    endtask

    task automatic test_stall();
        int in_idx;
        int out_idx;
        int cyc;
        logic [15:0] lfsr;
        logic hold_prev;
        logic [23:0] prev_pix;
        logic [7:0] g;
        logic [23:0] exp_pix;
        in_idx = 0; out_idx = 0; cyc = 0; lfsr = 16'hACE1; hold_prev = 1'b0; prev_pix = 24'h0;
        while (out_idx < 256 && cyc < 3000) begin
            g = 8'(in_idx);
            s_valid = (in_idx < 256);
            s_pixel = {3{g}};
            en      = g[0];
            m_ready = lfsr[0] | lfsr[5];
            #1;
            if (hold_prev) begin
                checks++; if (m_valid !== 1'b1 || m_pixel !== prev_pix) begin
                    errors++; $display("FAIL stall_hold cyc=%0d got v=%0b p=%h exp v=1 p=%h", cyc, m_valid, m_pixel, prev_pix); end
            end
            if (m_valid && m_ready) begin
                g = 8'(out_idx);
                exp_pix = g[0] ? pal_m[g] : {3{g}};
                checks++; if (m_pixel !== exp_pix) begin
                    errors++; $display("FAIL stall_out idx=%0d got=%h exp=%h", out_idx, m_pixel, exp_pix); end
                out_idx++;
            end
            hold_prev = m_valid && !m_ready;
            prev_pix  = m_pixel;
            if (s_valid && s_ready) in_idx++;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cyc++;
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        checks++; if (out_idx !== 256) begin errors++; $display("FAIL stall_count got=%0d exp=256", out_idx); end
        tick(); tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_extra got v=%0b exp=0", m_valid); end
    endtask

    task automatic test_reset_inflight();
        int seen;
        int n;
        m_ready = 1'b0;
        s_valid = 1'b1; s_pixel = 24'h303030; en = 1'b0;
        tick();
        s_pixel = 24'h313131;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_pixel !== 24'h303030) begin
            errors++; $display("FAIL inflight_pre got v=%0b p=%h exp v=1 p=303030", m_valid, m_pixel); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL inflight_rst got=%0b exp=0", m_valid); end
        seen = 0; n = 0;
`ifdef GRAY_TO_RGB_PALETTE_INIT_EN
        while (busy === 1'b1 && n < 400) begin
            if (m_valid !== 1'b0) seen++;
            n++;
            tick();
        end
        checks++; if (n !== 256) begin errors++; $display("FAIL reinit_cycles got=%0d exp=256", n); end
        model_identity();
`endif
        for (int i = 0; i < 8; i++) begin
            if (m_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL inflight_emitted got=%0d exp=0", seen); end
        s_valid = 1'b1; s_pixel = 24'h404040; en = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b1 || m_pixel !== 24'h404040) begin
            errors++; $display("FAIL post_rst got v=%0b p=%h exp v=1 p=404040", m_valid, m_pixel); end
    endtask

    initial begin
        test_reset();
`ifndef GRAY_TO_RGB_PALETTE_INIT_EN
        program_identity();
`endif
        test_latency();
        test_palette_write();
        test_back_to_back();
        test_read_first();
        test_stall();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
